pixel_queue: RTL and testbench

- Elastic FIFO between packet_generator and i2c_slave.
- Buffers every expanded brush/shape pixel (x, y, colour) so that pixels emitted back-to-back are not lost while the I2C host reads one pixel at a time.
- Presents the oldest pixel as a show-ahead head word and pops it when the host signals that a read has completed.
- Optionally suppresses consecutive duplicate pixels and reports overflow and drop statistics for the status byte.

---
 rtl/pixel_queue.sv | 141 ++++++++++++++
 tb/tb_pixel_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_queue.sv
// Elastic show-ahead pixel FIFO between the packet generator and the I2C slave.
// Optionally drops consecutive duplicate pixels and keeps overflow/drop statistics.
module pixel_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DEDUP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [7:0]    x_in,
  input  logic [7:0]    y_in,
  input  logic [2:0]    color_in,
  input  logic          pop,
  output logic [7:0]    head_x,
  output logic [7:0]    head_y,
  output logic [2:0]    head_color,
  output logic          head_valid,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    drop_count,
  output logic [7:0]    status
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [18:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          head_valid_q, head_valid_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          dedup_hit_q, dedup_hit_d;
  logic          last_valid_q, last_valid_d;
  logic [18:0]   last_word_q, last_word_d;

  logic [18:0] in_word;
  logic [18:0] head_word;
  logic        pop_eff;
  logic        is_dup;
  logic        accept;
  logic [3:0]  cnt4;

  assign in_word = {color_in, y_in, x_in};
  assign pop_eff = pop && head_valid_q;
  assign is_dup  = (DEDUP != 0) && last_valid_q && (in_word == last_word_q);
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign accept  = push && !is_dup && (!full_q || pop_eff);

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    dedup_hit_d  = dedup_hit_q;
    last_valid_d = last_valid_q;
    last_word_d  = last_word_q;

    if (push && is_dup) begin
      dedup_hit_d = 1'b1;
    end else if (push && !accept) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    if (accept) begin
      wr_ptr_d     = wr_ptr_q + PTR_ONE;
      last_word_d  = in_word;
      last_valid_d = 1'b1;
    end
    if (pop_eff) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({accept, pop_eff})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    full_d       = (count_d == CNT_MAX);
    head_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      dedup_hit_q  <= 1'b0;
      last_valid_q <= 1'b0;
      last_word_q  <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      dedup_hit_q  <= dedup_hit_d;
      last_valid_q <= last_valid_d;
      last_word_q  <= last_word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && accept) mem_q[wr_ptr_q] <= in_word;
  end

  // Gate the head so it reads zero while empty instead of stale storage.
  assign head_word  = head_valid_q ? mem_q[rd_ptr_q] : '0;
  assign head_x     = head_word[7:0];
  assign head_y     = head_word[15:8];
  assign head_color = head_word[18:16];
  assign head_valid = head_valid_q;
  assign full       = full_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

  generate
    if (AW >= 4) begin : g_cnt_sat
      assign cnt4 = (count_q > (AW+1)'(15)) ? 4'hF : count_q[3:0];
    end else begin : g_cnt_ext
      assign cnt4 = 4'(count_q);
    end
  endgenerate

  assign status = {head_valid_q, overflow_q, full_q, dedup_hit_q, cnt4};

endmodule

// File: tb/tb_pixel_queue.sv
// Bench for pixel_queue: directed vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_pixel_queue;

  logic       clk = 1'b0;
  logic       rst, clear, push, pop;
  logic [7:0] x_in, y_in;
  logic [2:0] color_in;
  logic [7:0] head_x, head_y;
  logic [2:0] head_color;
  logic       head_valid, full, overflow;
  logic [4:0] count;
  logic [7:0] drop_count, status;

  int total = 0;
  int bad   = 0;

  pixel_queue #(.DEPTH(16), .AW(4), .DEDUP(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push),
    .x_in(x_in), .y_in(y_in), .color_in(color_in), .pop(pop),
    .head_x(head_x), .head_y(head_y), .head_color(head_color),
    .head_valid(head_valid), .full(full), .count(count),
    .overflow(overflow), .drop_count(drop_count), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_status(input logic hv, input logic ovf, input logic fl,
                                            input logic dd, input int cnt);
    logic [3:0] c4;
    c4 = (cnt > 15) ? 4'hF : 4'(cnt);
    return {hv, ovf, fl, dd, c4};
  endfunction

  task automatic step(input logic r, input logic clr, input logic ps, input logic pp,
                      input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    rst = r; clear = clr; push = ps; pop = pp;
    x_in = x; y_in = y; color_in = c;
    @(posedge clk);
    #1;
    rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  function automatic logic [18:0] pix(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    return {c, y, x};
  endfunction

  typedef struct {
    logic        clr, psh, pp;
    logic [18:0] w;
    int          e_cnt;
    logic        e_hv, e_full, e_ovf, e_dd;
    int          e_drop;
    logic [18:0] e_head;
  } vec_t;

  function automatic vec_t mk(input logic clr, input logic psh, input logic pp, input logic [18:0] w,
                              input int cnt, input logic dd, input logic [18:0] hd);
    vec_t v;
    v.clr = clr; v.psh = psh; v.pp = pp; v.w = w;
    v.e_cnt = cnt; v.e_hv = (cnt != 0); v.e_full = (cnt == 16);
    v.e_ovf = 1'b0; v.e_drop = 0; v.e_dd = dd; v.e_head = hd;
    return v;
  endfunction

  vec_t tbl[15];

  // reference model state
  logic [18:0] mq[$];
  logic [18:0] m_last;
  logic        m_last_v, m_ovf, m_dd;
  int          m_drop;

  task automatic model_step(input logic r, input logic clr, input logic ps, input logic pp,
                            input logic [18:0] w);
    logic pop_eff, acc;
    acc = 1'b0;
    if (r || clr) begin
      mq.delete(); m_last_v = 1'b0; m_ovf = 1'b0; m_drop = 0; m_dd = 1'b0;
    end else begin
      pop_eff = pp && (mq.size() > 0);
      if (ps) begin
        if (m_last_v && w == m_last) m_dd = 1'b1;
        else if (mq.size() == 16 && !pop_eff) begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end else acc = 1'b1;
      end
      if (pop_eff) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(w); m_last = w; m_last_v = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".head_valid"}, 32'(head_valid), 32'(n != 0));
    chk({tag, ".full"}, 32'(full), 32'(n == 16));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".drop"}, 32'(drop_count), 32'(m_drop));
    chk({tag, ".status"}, 32'(status), 32'(exp_status(n != 0, m_ovf, n == 16, m_dd, n)));
    if (n != 0) chk({tag, ".head"}, 32'({head_color, head_y, head_x}), 32'(mq[0]));
  endtask

  initial begin
    logic [18:0] z;
    z = '0;
    tbl[0]  = mk(0, 1, 0, pix(10, 20, 3), 1, 0, pix(10, 20, 3));
    tbl[1]  = mk(0, 1, 0, pix(11, 20, 3), 2, 0, pix(10, 20, 3));
    tbl[2]  = mk(0, 1, 0, pix(12, 20, 3), 3, 0, pix(10, 20, 3));
    tbl[3]  = mk(0, 0, 1, z,              2, 0, pix(11, 20, 3));
    tbl[4]  = mk(0, 0, 1, z,              1, 0, pix(12, 20, 3));
    tbl[5]  = mk(0, 0, 1, z,              0, 0, z);
    tbl[6]  = mk(0, 1, 0, pix(5, 5, 1),   1, 0, pix(5, 5, 1));
    tbl[7]  = mk(0, 1, 0, pix(5, 5, 1),   1, 1, pix(5, 5, 1));
    tbl[8]  = mk(0, 1, 0, pix(5, 6, 1),   2, 1, pix(5, 5, 1));
    tbl[9]  = mk(0, 0, 1, z,              1, 1, pix(5, 6, 1));
    tbl[10] = mk(0, 0, 1, z,              0, 1, z);
    tbl[11] = mk(0, 1, 0, pix(5, 6, 1),   0, 1, z);
    tbl[12] = mk(0, 0, 1, z,              0, 1, z);
    tbl[13] = mk(0, 1, 1, pix(7, 7, 2),   1, 1, pix(7, 7, 2));
    tbl[14] = mk(1, 0, 0, z,              0, 0, z);

    rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0;
    x_in = '0; y_in = '0; color_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step(0, 0, 0, 0, 0, 0, 0);
    chk("rst.head_valid", 32'(head_valid), 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.full", 32'(full), 0);
    chk("rst.overflow", 32'(overflow), 0);
    chk("rst.drop", 32'(drop_count), 0);
    chk("rst.status", 32'(status), 32'h00);
    chk("rst.head", 32'({head_color, head_y, head_x}), 0);

    for (int i = 0; i < 15; i++) begin
      step(0, tbl[i].clr, tbl[i].psh, tbl[i].pp, tbl[i].w[7:0], tbl[i].w[15:8], tbl[i].w[18:16]);
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d.head_valid", i), 32'(head_valid), 32'(tbl[i].e_hv));
      chk($sformatf("vec%0d.full", i), 32'(full), 32'(tbl[i].e_full));
      chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
      chk($sformatf("vec%0d.drop", i), 32'(drop_count), 32'(tbl[i].e_drop));
      chk($sformatf("vec%0d.status", i), 32'(status),
          32'(exp_status(tbl[i].e_hv, tbl[i].e_ovf, tbl[i].e_full, tbl[i].e_dd, tbl[i].e_cnt)));
      if (tbl[i].e_hv)
        chk($sformatf("vec%0d.head", i), 32'({head_color, head_y, head_x}), 32'(tbl[i].e_head));
    end

    // fill to full, then two lost pushes
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'(i), 8'd50, 3'(i));
    step(0, 0, 1, 0, 8'd100, 8'd50, 3'd0);
    step(0, 0, 1, 0, 8'd101, 8'd50, 3'd0);
    chk("full.full", 32'(full), 1);
    chk("full.count", 32'(count), 16);
    chk("full.overflow", 32'(overflow), 1);
    chk("full.drop", 32'(drop_count), 2);
    chk("full.head", 32'({head_color, head_y, head_x}), 32'(pix(0, 50, 0)));
    chk("full.status", 32'(status), 32'hEF);
    step(0, 0, 1, 1, 8'd200, 8'd50, 3'd0);
    chk("fullpp.count", 32'(count), 16);
    chk("fullpp.drop", 32'(drop_count), 2);
    chk("fullpp.head", 32'({head_color, head_y, head_x}), 32'(pix(1, 50, 1)));

    repeat (10) step(0, 0, 0, 1, 0, 0, 0);
    chk("six.count", 32'(count), 6);
    chk("six.overflow", 32'(overflow), 1);
    chk("six.head", 32'({head_color, head_y, head_x}), 32'(pix(11, 50, 3)));
    step(0, 1, 1, 1, 8'd42, 8'd42, 3'd2);
    chk("clr.count", 32'(count), 0);
    chk("clr.head_valid", 32'(head_valid), 0);
    chk("clr.overflow", 32'(overflow), 0);
    chk("clr.drop", 32'(drop_count), 0);
    chk("clr.status", 32'(status), 32'h00);
    step(0, 0, 1, 0, 8'd200, 8'd50, 3'd0);
    chk("postclr.count", 32'(count), 1);
    chk("postclr.head", 32'({head_color, head_y, head_x}), 32'(pix(200, 50, 0)));

    // randomized run against the queue model; small value set so duplicates happen
    model_step(0, 1, 0, 0, '0);
    step(0, 1, 0, 0, 0, 0, 0);
    check_model("rnd.init");
    for (int n = 0; n < 3000; n++) begin
      logic r, clr, ps, pp;
      logic [18:0] w;
      r   = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 199) == 0);
      ps  = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 70 : 35));
      pp  = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 30 : 65));
      w   = pix(8'($urandom_range(0, 5)), 8'($urandom_range(0, 1)), 3'($urandom_range(0, 1)));
      model_step(r, clr, ps, pp, w);
      step(r, clr, ps, pp, w[7:0], w[15:8], w[18:16]);
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
